count_window_stats: RTL and testbench
=====================================

# count_window_stats

Downstream consumer of the 16-bit population-count stage. Takes one 5-bit ones-count per accepted input word through a valid/ready handshake, and gathers statistics over a fixed window of WINDOW words: sum, maximum, minimum and the number of all-ones words. At the end of each window it presents the result on a registered valid/ready output port, and it stalls its input until that result has been taken.

## Interface
- WINDOW, 8: words per window; legal range 1..255.
- SUM_W, 8: SUM_OUT width; must satisfy 2^SUM_W > 16*WINDOW.
- CNT_W, 4: FULL_CNT width; must satisfy 2^CNT_W > WINDOW.
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  reset; asynchronous and active-low.
- COUNT_IN  in  5  ones-count of one 16-bit word; legal values 0..16.
- IN_VALID  in  1  COUNT_IN is valid this cycle.
- IN_READY  out  1  block accepts COUNT_IN this cycle.
- SUM_OUT  out  SUM_W  sum of the window's (clamped) counts.
- MAX_OUT  out  5  largest count in the window.
- MIN_OUT  out  5  smallest count in the window.
- FULL_CNT  out  CNT_W  number of window words with count == 16.
- OUT_VALID  out  1  result outputs are valid.
- OUT_READY  in  1  downstream takes the result.
- ERR  out  1  sticky flag: a COUNT_IN > 16 was accepted.

## Operation
- States:
  - RUN: IN_READY=1, OUT_VALID=0.
  - HOLD: IN_READY=0, OUT_VALID=1.
- Accept: IN_VALID && IN_READY at a rising edge. Only accepted words affect state; gaps in IN_VALID are ignored.
- Clamping: an accepted COUNT_IN > 16 is processed as 16 and sets ERR. ERR is cleared only by reset.
- Running registers, reset at window start:
  - acc_sum = 0, acc_max = 0, acc_min = 16, acc_full = 0, word index idx = 0.
- Non-final accept (idx < WINDOW-1):
  - acc_sum += v; acc_max = max(acc_max, v); acc_min = min(acc_min, v); acc_full += (v == 16); idx++.
- Final accept (idx == WINDOW-1):
  - Outputs load the totals including v.
  - Running registers return to their window-start values; idx = 0.
  - State moves to HOLD.
- HOLD:
  - Outputs are frozen.
  - When OUT_VALID && OUT_READY at an edge, the state returns to RUN.
- Arithmetic is unsigned with no overflow, guaranteed by the SUM_W and CNT_W rules.
- WINDOW = 1: every accepted word produces a result with SUM_OUT = MAX_OUT = MIN_OUT = v.

## Timing
- Reset values:
  - IN_READY = 0, OUT_VALID = 0, SUM_OUT = 0, MAX_OUT = 0, MIN_OUT = 0, FULL_CNT = 0, ERR = 0.
  - Internal state = RUN with window-start values.
- After reset release:
  - IN_READY rises at the first rising CLK edge after RST_N goes high.
  - The first accept is possible at the following edge.
- Latency: OUT_VALID and the results are valid in the cycle immediately after the edge that accepted the final word.
- Output handshake: while OUT_VALID=1 and OUT_READY=0, all outputs stay stable for any number of cycles.
- Return to RUN:
  - The edge that completes the output handshake clears OUT_VALID and sets IN_READY.
  - No input is accepted in that same edge.
- Throughput: WINDOW+1 cycles per window when IN_VALID and OUT_READY are held high (one bubble per window).
- IN_READY and OUT_VALID are registered state decodes; neither depends combinationally on IN_VALID or OUT_READY.
- Reset asserted mid-window or during HOLD:
  - Immediate, asynchronous return to the reset values above.
  - The partial window and any pending result are discarded.

## Test plan
- WINDOW=4, SUM_W=7, CNT_W=3. Accept 3,16,0,7 with OUT_READY=1 -> one cycle later OUT_VALID=1, SUM_OUT=26, MAX_OUT=16, MIN_OUT=0, FULL_CNT=1, ERR=0.
- Same window with OUT_READY=0 for 5 cycles -> IN_READY=0 and outputs constant throughout. Raise OUT_READY -> OUT_VALID=0 and IN_READY=1 on the next cycle.
- Accept 20,1,1,1 -> SUM_OUT=19, MAX_OUT=16, FULL_CNT=1, ERR=1. ERR stays 1 across following windows until RST_N is pulsed.
- Accept 5,5, then pulse RST_N low mid-cycle -> all outputs 0 immediately. Then accept 2,2,2,2 -> SUM_OUT=8, MIN_OUT=2, MAX_OUT=2.
- Continuous IN_VALID=1 and OUT_READY=1, 3 windows of all-16 words -> OUT_VALID pulses every 5 cycles, each with SUM_OUT=64, FULL_CNT=4.
- IN_VALID toggled 1,0,0,1,0,1,1 carrying 9,x,x,4,x,12,0 (x = don't-care values not accepted) -> only the four valid words counted: SUM_OUT=25, MAX_OUT=12, MIN_OUT=0.

Source files
------------

// File: rtl/count_window_stats_if.sv
// Handshake bundle between the popcount stage, the window statistics block and its result consumer.
interface count_window_stats_if #(
  parameter int SUM_W = 8,
  parameter int CNT_W = 4
);
  logic [4:0]       count_in;
  logic             in_vld;
  logic             in_rdy;
  logic [SUM_W-1:0] sum_out;
  logic [4:0]       max_out;
  logic [4:0]       min_out;
  logic [CNT_W-1:0] full_cnt;
  logic             out_vld;
  logic             out_rdy;
  logic             err;

  modport slave (
    input  count_in, in_vld, out_rdy,
    output in_rdy, sum_out, max_out, min_out, full_cnt, out_vld, err
  );

  modport master (
    output count_in, in_vld, out_rdy,
    input  in_rdy, sum_out, max_out, min_out, full_cnt, out_vld, err
  );
endinterface

// File: rtl/count_window_stats.sv
// Windowed sum/max/min/all-ones statistics over WINDOW popcounts; result registered one cycle after the final accept.
// Input stalls (in_rdy=0) while a result is held until out_rdy takes it; one bubble cycle per window.
module count_window_stats #(
  parameter int WINDOW = 8,
  parameter int SUM_W  = 8,
  parameter int CNT_W  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  count_window_stats_if.slave bus
);

  localparam int IDX_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  // ST_INIT only exists so in_rdy stays low for the first edge after reset.
  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HOLD} state_e;

  state_e           state_q, state_d;
  logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
  logic [4:0]       acc_max_q, acc_max_d;
  logic [4:0]       acc_min_q, acc_min_d;
  logic [CNT_W-1:0] acc_full_q, acc_full_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [4:0]       max_q, max_d;
  logic [4:0]       min_q, min_d;
  logic [CNT_W-1:0] full_q, full_d;
  logic             err_q, err_d;

  logic             over;
  logic [4:0]       v;
  logic             accept;
  logic             is_full;
  logic [SUM_W-1:0] sum_tot;
  logic [4:0]       max_tot;
  logic [4:0]       min_tot;
  logic [CNT_W-1:0] full_tot;

  always_comb begin
    over     = bus.count_in > 5'd16;
    v        = over ? 5'd16 : bus.count_in;
    accept   = (state_q == ST_RUN) && bus.in_vld;
    is_full  = (v == 5'd16);
    sum_tot  = acc_sum_q + SUM_W'(v);
    max_tot  = (v > acc_max_q) ? v : acc_max_q;
    min_tot  = (v < acc_min_q) ? v : acc_min_q;
    full_tot = acc_full_q + CNT_W'(is_full);

    state_d    = state_q;
    acc_sum_d  = acc_sum_q;
    acc_max_d  = acc_max_q;
    acc_min_d  = acc_min_q;
    acc_full_d = acc_full_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    max_d      = max_q;
    min_d      = min_q;
    full_d     = full_q;
    err_d      = err_q;

    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        if (accept) begin
          err_d = err_q | over;
          if (idx_q == LAST_IDX) begin
            sum_d      = sum_tot;
            max_d      = max_tot;
            min_d      = min_tot;
            full_d     = full_tot;
            acc_sum_d  = '0;
            acc_max_d  = 5'd0;
            acc_min_d  = 5'd16;
            acc_full_d = '0;
            idx_d      = '0;
            state_d    = ST_HOLD;
          end else begin
            acc_sum_d  = sum_tot;
            acc_max_d  = max_tot;
            acc_min_d  = min_tot;
            acc_full_d = full_tot;
            idx_d      = idx_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_rdy) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      acc_sum_q  <= '0;
      acc_max_q  <= 5'd0;
      acc_min_q  <= 5'd16;
      acc_full_q <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      max_q      <= 5'd0;
      min_q      <= 5'd0;
      full_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_sum_q  <= acc_sum_d;
      acc_max_q  <= acc_max_d;
      acc_min_q  <= acc_min_d;
      acc_full_q <= acc_full_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      min_q      <= min_d;
      full_q     <= full_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_rdy   = (state_q == ST_RUN);
  assign bus.out_vld  = (state_q == ST_HOLD);
  assign bus.sum_out  = sum_q;
  assign bus.max_out  = max_q;
  assign bus.min_out  = min_q;
  assign bus.full_cnt = full_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_count_window_stats.sv
// Directed bench for count_window_stats at WINDOW=4 with hand-computed window results.
module tb_count_window_stats;
  localparam int WINDOW = 4;
  localparam int SUM_W  = 7;
  localparam int CNT_W  = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  count_window_stats_if #(.SUM_W(SUM_W), .CNT_W(CNT_W)) bus ();

  count_window_stats #(.WINDOW(WINDOW), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the word until accepted, bounded so a stuck in_rdy cannot hang the run.
  task automatic send(input logic [4:0] val);
    int waited;
    bus.count_in = val;
    bus.in_vld   = 1'b1;
    waited = 0;
    while (!bus.in_rdy && waited < 20) begin
      step();
      waited++;
    end
    if (!bus.in_rdy) chk("send_timeout_in_rdy", 32'(bus.in_rdy), 1);
    step();
    bus.in_vld = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int s, input int mx, input int mn,
                            input int fc, input int e);
    chk({tag, "_vld"},  32'(bus.out_vld), 1);
    chk({tag, "_sum"},  32'(bus.sum_out), s);
    chk({tag, "_max"},  32'(bus.max_out), mx);
    chk({tag, "_min"},  32'(bus.min_out), mn);
    chk({tag, "_full"}, 32'(bus.full_cnt), fc);
    chk({tag, "_err"},  32'(bus.err), e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_rdy"}, 32'(bus.in_rdy), 0);
    chk({tag, "_vld"},    32'(bus.out_vld), 0);
    chk({tag, "_sum"},    32'(bus.sum_out), 0);
    chk({tag, "_max"},    32'(bus.max_out), 0);
    chk({tag, "_min"},    32'(bus.min_out), 0);
    chk({tag, "_full"},   32'(bus.full_cnt), 0);
    chk({tag, "_err"},    32'(bus.err), 0);
  endtask

  initial begin
    logic [4:0] gap_dat [7];
    logic       gap_vld [7];
    int pulses;

    n_checks = 0;
    n_errors = 0;
    rst_n        = 1'b0;
    bus.count_in = 5'd0;
    bus.in_vld   = 1'b0;
    bus.out_rdy  = 1'b0;

    step();
    step();
    chk_zero("reset");
    #2 rst_n = 1'b1;
    step();
    chk("post_reset_in_rdy", 32'(bus.in_rdy), 1);

    // Window 1: 3,16,0,7 consumed immediately.
    bus.out_rdy = 1'b1;
    send(5'd3); send(5'd16); send(5'd0); send(5'd7);
    chk_result("w1", 26, 16, 0, 1, 0);
    chk("w1_in_rdy", 32'(bus.in_rdy), 0);
    step();
    chk("w1_done_vld", 32'(bus.out_vld), 0);
    chk("w1_done_in_rdy", 32'(bus.in_rdy), 1);

    // Window 2: downstream stalls for 5 cycles.
    bus.out_rdy = 1'b0;
    send(5'd3); send(5'd16); send(5'd0); send(5'd7);
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_rdy", 32'(bus.in_rdy), 0);
      chk_result("stall", 26, 16, 0, 1, 0);
      step();
    end
    bus.out_rdy = 1'b1;
    step();
    chk("stall_done_vld", 32'(bus.out_vld), 0);
    chk("stall_done_in_rdy", 32'(bus.in_rdy), 1);

    // Window 3: out-of-range word clamps and sets sticky err.
    send(5'd20); send(5'd1); send(5'd1); send(5'd1);
    chk_result("clamp", 19, 16, 1, 1, 1);
    step();
    send(5'd2); send(5'd2); send(5'd2); send(5'd2);
    chk_result("sticky", 8, 2, 2, 0, 1);
    step();

    // Partial window discarded by a mid-cycle reset pulse.
    send(5'd5); send(5'd5);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    #3 rst_n = 1'b1;
    step();
    chk("midreset_in_rdy", 32'(bus.in_rdy), 1);
    send(5'd2); send(5'd2); send(5'd2); send(5'd2);
    chk_result("after_reset", 8, 2, 2, 0, 0);
    step();

    // Streaming all-16 words: one result every WINDOW+1 cycles.
    bus.count_in = 5'd16;
    bus.in_vld   = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 15) bus.in_vld = 1'b0;
      chk("stream_vld", 32'(bus.out_vld), ((k % 5) == 4) ? 1 : 0);
      if (bus.out_vld) begin
        pulses++;
        chk("stream_sum", 32'(bus.sum_out), 64);
        chk("stream_full", 32'(bus.full_cnt), 4);
      end
    end
    chk("stream_pulses", 32'(pulses), 3);

    // Gappy input: unaccepted cycles carry 16 so a leak would show in max/full.
    gap_vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    gap_dat = '{5'd9, 5'd16, 5'd16, 5'd4, 5'd16, 5'd12, 5'd0};
    for (int i = 0; i < 7; i++) begin
      bus.count_in = gap_dat[i];
      bus.in_vld   = gap_vld[i];
      step();
    end
    bus.in_vld = 1'b0;
    chk_result("gaps", 25, 12, 0, 0, 0);
    step();
    chk("gaps_done_vld", 32'(bus.out_vld), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
